band_select_ctrl: RTL and testbench
===================================

// Module: band_select_ctrl
// PURPOSE
//   Sequences the 2-bit selector of the equalizer output multiplexer.
//   - Selects bass (00), mid (01), treble (10) or full signal (11).
//   - Band changes come from a front-panel button or a built-in auto-scan timer.
//   - Switches happen only on codec sample boundaries, inside a short mute window,
//     so band changes are click-free. Sits between the panel inputs and the mux sel port.
// PARAMETERS
//   SEL_W        2      selector width; must be 2.
//   DEB_CYCLES   50000  clk cycles a synchronized button must stay stable to be accepted.
//   MUTE_SAMPLES 4      sample ticks mute stays high per switch; must be >= 2.
//   SCAN_SAMPLES 48000  sample ticks between automatic band steps while auto mode is on.
// PORTS
//   clk          in   1      system clock.
//   reset        in   1      asynchronous, active-high reset.
//   btn_next     in   1      raw, asynchronous button: step to next band.
//   btn_auto     in   1      raw, asynchronous button: toggle auto-scan mode.
//   sample_tick  in   1      one-clk strobe, once per audio sample.
//   sel          out  SEL_W  registered selector to the output mux.
//   mute         out  1      registered; high forces the output sample to zero downstream.
//   busy         out  1      high in any state other than IDLE.
//   auto_on      out  1      high while auto-scan mode is enabled.
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; all counters and req_pend cleared.
//     Outputs: sel=00, mute=0, busy=0, auto_on=0.
//   Input conditioning (each button independently):
//     - 2-flop synchronizer, then a debounce counter.
//     - Debounced level changes only after DEB_CYCLES consecutive equal samples.
//     - A 0->1 edge of the debounced level makes a one-clk pulse
//       (next_pulse, auto_pulse). Latency: 2 + DEB_CYCLES clk after the input settles.
//   auto_pulse toggles auto_on, in any state.
//     - Turning auto off clears scan_cnt.
//   Auto-scan:
//     - scan_cnt counts sample_ticks only while auto_on=1 and state=IDLE.
//     - When the count reaches SCAN_SAMPLES it raises an internal request and clears.
//     - A manual next_pulse also clears scan_cnt.
//   Request handling:
//     - In IDLE, a request starts a switch.
//     - While busy, the first request sets req_pend; any further requests are dropped.
//     - On return to IDLE with req_pend=1: clear req_pend, start the next switch
//       on the next clk.
//     - Manual and auto requests in the same clk count as one request.
//   FSM:
//     - IDLE: mute=0. On request: nxt_sel = sel+1 (mod 4, wraps 11->00); go ARM.
//     - ARM: wait for sample_tick. On tick: mute<=1, mcnt<=0, go MUTED.
//       Mute rises on a sample boundary.
//     - MUTED: counts sample_ticks.
//       - Tick with mcnt==0: sel<=nxt_sel, mcnt<=1. The selector changes one full sample
//         after mute rises.
//       - Tick with mcnt==MUTE_SAMPLES-1: mute<=0, go IDLE.
//       - Any other tick: mcnt++.
//       - Net effect: mute is high for exactly MUTE_SAMPLES ticks.
//       - sel never changes outside MUTED.
//   sample_tick coinciding with a request in IDLE is not consumed; ARM waits for the
//   following tick.
//   If sample_tick stops, the FSM holds its state indefinitely. No timeout.
// TESTING (bench params: DEB_CYCLES=4, MUTE_SAMPLES=3, SCAN_SAMPLES=8; tick every 10 clk)
//   1 Reset then idle 100 clk -> sel=00, mute=0, busy=0, auto_on=0 throughout.
//   2 btn_next held high 20 clk -> exactly one switch.
//       - mute rises on the first tick after ARM.
//       - sel 00->01 on the next tick.
//       - mute falls on the 3rd tick after it rose.
//       - busy then drops.
//   3 btn_next bouncing (1 clk pulses, 3 clk gaps) then stable -> single step only.
//     Four clean presses -> sel sequence 01,10,11,00 (wrap).
//   4 Press btn_next twice during one switch, then once more while busy -> two total steps,
//     back-to-back (00->01->10); third press dropped.
//   5 btn_auto press -> auto_on=1; sel steps every 8 idle ticks plus switch time.
//     Second btn_auto press -> auto_on=0, no further steps.
//   6 Assert reset while in MUTED with sel=10 -> same clk async: sel=00, mute=0, busy=0,
//     auto_on=0. A fresh press afterwards steps to 01 normally.

Source files
------------

// File: rtl/band_select_ctrl.sv
// band_select_ctrl: click-free band selector sequencer for the equalizer output mux.
// Button inputs are synchronized and debounced; band switches are requested manually
// or by an auto-scan timer, and applied on sample boundaries inside a mute window.

// Per-button conditioning: 2-flop synchronizer, debounce counter, rising-edge pulse.
module band_select_ctrl_deb #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic s1_q, s1_d, s2_q, s2_d;
  logic deb_q, deb_d, prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounced level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    s1_d   = raw;
    s2_d   = s1_q;
    prev_d = deb_q;
    deb_d  = deb_q;
    cnt_d  = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Conditioning registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      deb_q  <= deb_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pulse = deb_q & ~prev_q;
endmodule

module band_select_ctrl #(
  parameter int SEL_W        = 2,
  parameter int DEB_CYCLES   = 50000,
  parameter int MUTE_SAMPLES = 4,
  parameter int SCAN_SAMPLES = 48000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_next,
  input  logic             btn_auto,
  input  logic             sample_tick,
  output logic [SEL_W-1:0] sel,
  output logic             mute,
  output logic             busy,
  output logic             auto_on
);
  localparam int MCNT_W = $clog2(MUTE_SAMPLES + 1);
  localparam int SCAN_W = $clog2(SCAN_SAMPLES + 1);
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MUTE_SAMPLES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_SAMPLES - 1);

  typedef enum logic [1:0] {IDLE, ARM, MUTED} state_t;

  state_t state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, nxt_sel_q, nxt_sel_d;
  logic              mute_q, mute_d, auto_on_q, auto_on_d, req_pend_q, req_pend_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;

  // bit 0: next button, bit 1: auto button
  logic [1:0] btn_raw, btn_pulse;
  logic       next_pulse, auto_pulse, scan_hit, req, mcnt_last;

  assign btn_raw = {btn_auto, btn_next};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : gen_deb
      band_select_ctrl_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[g]),
        .pulse (btn_pulse[g])
      );
    end
  endgenerate

  assign next_pulse = btn_pulse[0];
  assign auto_pulse = btn_pulse[1];
  assign mcnt_last  = (mcnt_q == MCNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: a pending request restarts a switch straight from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req || req_pend_q)          state_d = ARM;
      ARM:     if (sample_tick)                state_d = MUTED;
      MUTED:   if (sample_tick && mcnt_last)   state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  // Datapath: auto-scan timer, request merging/pending, mute window and selector.
  always_comb begin
    sel_d      = sel_q;
    nxt_sel_d  = nxt_sel_q;
    mute_d     = mute_q;
    mcnt_d     = mcnt_q;
    req_pend_d = req_pend_q;
    auto_on_d  = auto_on_q ^ auto_pulse;
    scan_cnt_d = scan_cnt_q;

    scan_hit = auto_on_q && (state_q == IDLE) && sample_tick && (scan_cnt_q == SCAN_LAST);
    // manual and auto request in the same clk collapse into one
    req      = next_pulse | scan_hit;

    if (auto_pulse && auto_on_q)
      scan_cnt_d = '0;
    else if (next_pulse)
      scan_cnt_d = '0;
    else if (auto_on_q && (state_q == IDLE) && sample_tick)
      scan_cnt_d = scan_hit ? '0 : scan_cnt_q + SCAN_W'(1);

    case (state_q)
      IDLE: begin
        mute_d = 1'b0;
        if (req || req_pend_q) begin
          nxt_sel_d = sel_q + SEL_W'(1);
          // a fresh request arriving as the pending one is launched stays queued
          req_pend_d = req_pend_q & req;
        end
      end
      ARM: begin
        if (req) req_pend_d = 1'b1;
        if (sample_tick) begin
          mute_d = 1'b1;
          mcnt_d = '0;
        end
      end
      MUTED: begin
        if (req) req_pend_d = 1'b1;
        if (sample_tick) begin
          if (mcnt_last) begin
            mute_d = 1'b0;
          end else if (mcnt_q == '0) begin
            sel_d  = nxt_sel_q;
            mcnt_d = MCNT_W'(1);
          end else begin
            mcnt_d = mcnt_q + MCNT_W'(1);
          end
        end
      end
      default: mute_d = 1'b0;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q      <= '0;
      nxt_sel_q  <= '0;
      mute_q     <= 1'b0;
      mcnt_q     <= '0;
      req_pend_q <= 1'b0;
      auto_on_q  <= 1'b0;
      scan_cnt_q <= '0;
    end else begin
      sel_q      <= sel_d;
      nxt_sel_q  <= nxt_sel_d;
      mute_q     <= mute_d;
      mcnt_q     <= mcnt_d;
      req_pend_q <= req_pend_d;
      auto_on_q  <= auto_on_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  // Outputs.
  always_comb begin
    sel     = sel_q;
    mute    = mute_q;
    auto_on = auto_on_q;
    busy    = (state_q != IDLE);
  end
endmodule

// File: tb/tb_band_select_ctrl.sv
// Scoreboard bench for band_select_ctrl: a cycle-stepped behavioural model predicts
// every output transition (kind, value, cycle); a monitor matches DUT transitions.
module tb_band_select_ctrl;
  localparam int DEB = 4;
  localparam int MS  = 3;
  localparam int SS  = 8;

  logic       clk = 1'b0, reset = 1'b1;
  logic       btn_next = 1'b0, btn_auto = 1'b0, sample_tick = 1'b0;
  logic [1:0] sel;
  logic       mute, busy, auto_on;

  band_select_ctrl #(.SEL_W(2), .DEB_CYCLES(DEB), .MUTE_SAMPLES(MS), .SCAN_SAMPLES(SS)) dut (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_auto(btn_auto),
    .sample_tick(sample_tick), .sel(sel), .mute(mute), .busy(busy), .auto_on(auto_on)
  );

  always #5 clk = ~clk;

  int     checks = 0, errors = 0;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sample tick every 10 clk, driven away from the active edge
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tc = (tc == 9) ? 0 : tc + 1;
      sample_tick = (tc == 0);
    end
  end

  // ---------------- reference model ----------------
  typedef struct {int kind; int val; longint cyc;} ev_t;
  ev_t q[$];

  int m_sel, m_mute, m_auto, m_phase, m_mt, m_scan;
  bit m_pend, m_deb_n, m_deb_a, m_pul_n, m_pul_a;
  bit hn[$], ha[$];
  int o_sel, o_mute, o_auto, o_busy, o_phase;
  bit np, ap, hit, req, fl;

  // button accepted when the samples taken 2..DEB+1 edges ago all oppose the level
  function automatic bit opposes(input bit h[$], input bit lvl);
    for (int i = 2; i < DEB + 2; i++) if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_sel = 0; m_mute = 0; m_auto = 0; m_phase = 0; m_mt = 0; m_scan = 0;
    m_pend = 0; m_deb_n = 0; m_deb_a = 0; m_pul_n = 0; m_pul_a = 0;
    hn.delete(); ha.delete();
    for (int i = 0; i < DEB + 2; i++) begin hn.push_back(1'b0); ha.push_back(1'b0); end
  endtask

  task automatic push_ev(input int k, input int v);
    ev_t e;
    e.kind = k; e.val = v; e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reset();
      q.delete();
    end else begin
      o_sel = m_sel; o_mute = m_mute; o_auto = m_auto; o_phase = m_phase;
      o_busy = (m_phase != 0);
      np = m_pul_n; ap = m_pul_a;
      hn.push_front(btn_next); void'(hn.pop_back());
      ha.push_front(btn_auto); void'(ha.pop_back());

      hit = (m_auto != 0) && (o_phase == 0) && sample_tick && (m_scan == SS - 1);
      req = np || hit;
      if (ap && m_auto != 0)                          m_scan = 0;
      else if (np)                                    m_scan = 0;
      else if (m_auto != 0 && o_phase == 0 && sample_tick) m_scan = hit ? 0 : m_scan + 1;

      if (o_phase == 0) begin
        if (req || m_pend) begin m_pend = m_pend && req; m_phase = 1; end
      end else if (req) m_pend = 1;

      if (o_phase == 1 && sample_tick) begin
        m_mute = 1; m_mt = 0; m_phase = 2;
      end else if (o_phase == 2 && sample_tick) begin
        m_mt++;
        if (m_mt == 1) m_sel = (m_sel + 1) % 4;
        if (m_mt == MS) begin m_mute = 0; m_phase = 0; end
      end
      if (ap) m_auto = 1 - m_auto;

      fl = opposes(hn, m_deb_n); if (fl) m_deb_n = ~m_deb_n; m_pul_n = fl && m_deb_n;
      fl = opposes(ha, m_deb_a); if (fl) m_deb_a = ~m_deb_a; m_pul_a = fl && m_deb_a;

      if (m_sel != o_sel)                push_ev(0, m_sel);
      if (m_mute != o_mute)              push_ev(1, m_mute);
      if (m_auto != o_auto)              push_ev(2, m_auto);
      if (int'(m_phase != 0) != o_busy)  push_ev(3, int'(m_phase != 0));
    end
  end

  // ---------------- monitor ----------------
  int pv[4];
  initial for (int i = 0; i < 4; i++) pv[i] = 0;

  always @(negedge clk) begin
    int cur;
    ev_t e;
    if (reset) begin
      for (int k = 0; k < 4; k++) pv[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        cur = (k == 0) ? int'(sel) : (k == 1) ? int'(mute) : (k == 2) ? int'(auto_on) : int'(busy);
        if (cur != pv[k]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change kind=%0d got=%0d cyc=%0d (no event expected)", k, cur, cyc);
          end else begin
            e = q.pop_front();
            if (e.kind != k || e.val != cur || e.cyc != cyc) begin
              errors++;
              $display("FAIL event kind=%0d val=%0d cyc=%0d expected kind=%0d val=%0d cyc=%0d",
                       k, cur, cyc, e.kind, e.val, e.cyc);
            end
          end
          pv[k] = cur;
        end
      end
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        checks++; errors++;
        $display("FAIL missed_event kind=%0d expected val=%0d at cyc=%0d, now cyc=%0d", e.kind, e.val, e.cyc, cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) btn_next = 1'b1; else btn_auto = 1'b1;
    idle(hold);
    if (which == 0) btn_next = 1'b0; else btn_auto = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    idle(3);
    reset = 1'b0;
    chk("reset_sel", sel, 0); chk("reset_mute", mute, 0);
    chk("reset_busy", busy, 0); chk("reset_auto", auto_on, 0);
    idle(100);
    chk("idle_sel", sel, 0); chk("idle_busy", busy, 0);

    // single long press -> one step
    press(0, 20); idle(100);
    chk("one_step_sel", sel, 1);

    // bouncing then stable -> a single step
    for (int i = 0; i < 4; i++) begin btn_next = 1'b1; idle(1); btn_next = 1'b0; idle(3); end
    press(0, 20); idle(100);
    chk("bounce_sel", sel, 2);

    // four clean presses -> 11, 00, 01, 10 (wraps through 00)
    for (int i = 0; i < 4; i++) begin press(0, 8); idle(80); end
    chk("wrap_sel", sel, 2);

    // three quick presses during one switch -> two steps
    do_reset();
    press(0, 6); idle(6); press(0, 6); idle(6); press(0, 6); idle(150);
    chk("pend_sel", sel, 2); chk("pend_busy", busy, 0);

    // auto scan on, then off
    press(1, 8); idle(10);
    chk("auto_on", auto_on, 1);
    idle(400);
    press(1, 8); idle(10);
    chk("auto_off", auto_on, 0);
    idle(200);

    // reset while muted with sel=10
    do_reset();
    press(0, 8); idle(80);
    press(0, 8);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_phase == 2 && m_sel == 2) found = 1'b1; else @(negedge clk);
    end
    chk("reach_muted_sel2", int'(found), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_sel", sel, 0); chk("async_mute", mute, 0);
    chk("async_busy", busy, 0); chk("async_auto", auto_on, 0);
    idle(2); reset = 1'b0;
    press(0, 8); idle(80);
    chk("post_reset_sel", sel, 1);

    // random presses with occasional bounce
    for (int i = 0; i < 60; i++) begin
      int w;
      w = ($urandom_range(0, 9) < 8) ? 0 : 1;
      if ($urandom_range(0, 2) == 0)
        for (int b = 0; b < 3; b++) begin
          if (w == 0) btn_next = 1'b1; else btn_auto = 1'b1;
          idle($urandom_range(1, 3));
          btn_next = 1'b0; btn_auto = 1'b0;
          idle($urandom_range(1, 3));
        end
      press(w, $urandom_range(1, 12));
      idle($urandom_range(1, 70));
    end
    idle(200);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
